// File: rtl/mu0_pkg.sv
// Shared types and opcode constants for the MU0 control sequencer.
package mu0_pkg;

    // Sequencer control states, binary encoded.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_PAUSE = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    // Opcode map; 12..15 are unassigned and treated as illegal.
    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JNE = 4'd5;
    localparam logic [3:0] OP_JEQ = 4'd6;
    localparam logic [3:0] OP_STP = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_LSL = 4'd9;
    localparam logic [3:0] OP_LSR = 4'd10;
    localparam logic [3:0] OP_JGE = 4'd11;

    localparam int OP_LAST_LEGAL = 11;

    // True when the opcode lies outside the implemented instruction set.
    function automatic logic op_is_illegal(input logic [3:0] op);
        return op > 4'(OP_LAST_LEGAL);
    endfunction

endpackage

// File: rtl/mu0_event_counter.sv
// Wrapping event counter with synchronous clear and increment enable.
module mu0_event_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Clear wins over increment so a restart always begins from zero.
    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 control sequencer: FETCH/EXEC1/EXEC2 phase generation with memory
// stalls, run/halt, single-step, illegal-opcode fault and event counters.
module mu0_sequencer
    import mu0_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit AUTO_START = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             mem_ready,
    input  logic [3:0]       op,
    input  logic             EXTRA,
    output logic             FETCH,
    output logic             EXEC1,
    output logic             EXEC2,
    output logic             busy,
    output logic             paused,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam state_t RESET_STATE = AUTO_START ? ST_FETCH : ST_IDLE;

    state_t state;
    logic   op_illegal;
    logic   retire;
    logic   complete;
    logic   restart;

    assign op_illegal = op_is_illegal(op);

    // A start only counts from IDLE or HALT; it also wipes counters and fault.
    assign restart = start && (state == ST_IDLE || state == ST_HALT);

    // Retire/complete qualifiers; STP retires but heads to HALT, not onward.
    always_comb begin
        retire   = 1'b0;
        complete = 1'b0;
        case (state)
            ST_EXEC1: begin
                if (op_illegal) begin
                    retire = 1'b0;
                end else if (op == OP_STP) begin
                    retire = 1'b1;
                end else if (op == OP_STA) begin
                    retire   = mem_ready;
                    complete = mem_ready;
                end else if (!EXTRA) begin
                    retire   = 1'b1;
                    complete = 1'b1;
                end
            end
            ST_EXEC2: begin
                retire   = 1'b1;
                complete = 1'b1;
            end
            default: begin
                retire   = 1'b0;
                complete = 1'b0;
            end
        endcase
    end

    // Control state machine and sticky fault flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RESET_STATE;
            fault <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state <= ST_FETCH;
                        fault <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (mem_ready)
                        state <= ST_EXEC1;
                end
                ST_EXEC1: begin
                    if (op_illegal) begin
                        state <= ST_HALT;
                        fault <= 1'b1;
                    end else if (op == OP_STP) begin
                        state <= ST_HALT;
                    end else if (complete) begin
                        state <= step_mode ? ST_PAUSE : ST_FETCH;
                    end else if (op != OP_STA && EXTRA && mem_ready) begin
                        state <= ST_EXEC2;
                    end
                end
                ST_EXEC2: begin
                    state <= step_mode ? ST_PAUSE : ST_FETCH;
                end
                ST_PAUSE: begin
                    if (step || !step_mode)
                        state <= ST_FETCH;
                end
                default: begin
                    state <= RESET_STATE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state register.
    assign FETCH  = (state == ST_FETCH);
    assign EXEC1  = (state == ST_EXEC1);
    assign EXEC2  = (state == ST_EXEC2);
    assign busy   = FETCH || EXEC1 || EXEC2;
    assign paused = (state == ST_PAUSE);
    assign halted = (state == ST_HALT);

    mu0_event_counter #(.CNT_W(CNT_W)) u_instr_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (restart),
        .inc   (retire),
        .count (instr_count)
    );

    mu0_event_counter #(.CNT_W(CNT_W)) u_cycle_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (restart),
        .inc   (busy),
        .count (cycle_count)
    );

endmodule

// File: tb/tb_mu0_sequencer.sv
// Scoreboard bench for mu0_sequencer: two instances (16-bit/manual start and
// 4-bit/auto start) driven in lockstep and compared against a reference model.
module tb_mu0_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] op = 4'd0;
    logic       extra = 1'b0;

    logic        f_a, e1_a, e2_a, busy_a, paused_a, halted_a, fault_a;
    logic [15:0] ic_a, cc_a;
    logic        f_b, e1_b, e2_b, busy_b, paused_b, halted_b, fault_b;
    logic [3:0]  ic_b, cc_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mu0_sequencer #(.CNT_W(16), .AUTO_START(1'b0)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
        .step(step), .mem_ready(mem_ready), .op(op), .EXTRA(extra),
        .FETCH(f_a), .EXEC1(e1_a), .EXEC2(e2_a), .busy(busy_a),
        .paused(paused_a), .halted(halted_a), .fault(fault_a),
        .instr_count(ic_a), .cycle_count(cc_a)
    );

    mu0_sequencer #(.CNT_W(4), .AUTO_START(1'b1)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode),
        .step(step), .mem_ready(mem_ready), .op(op), .EXTRA(extra),
        .FETCH(f_b), .EXEC1(e1_b), .EXEC2(e2_b), .busy(busy_b),
        .paused(paused_b), .halted(halted_b), .fault(fault_b),
        .instr_count(ic_b), .cycle_count(cc_b)
    );

    // Reference model: where each instance is, plus its architectural counters.
    localparam int M_IDLE = 0, M_FETCH = 1, M_E1 = 2, M_E2 = 3, M_PAUSE = 4, M_HALT = 5;
    localparam int K_BAD = 0, K_STOP = 1, K_STORE = 2, K_LOAD = 3, K_SIMPLE = 4;

    int m_st[2];
    bit m_fault[2];
    int m_ic[2];
    int m_cc[2];

    typedef struct {
        int k;
        int st;
        bit fault;
        int ic;
        int cc;
    } exp_t;

    exp_t sb[$];

    // What kind of work an instruction needs once it reaches EXEC1.
    function automatic int instr_kind(input logic [3:0] o, input logic x);
        if (o >= 4'd12) return K_BAD;
        if (o == 4'd7) return K_STOP;
        if (o == 4'd1) return K_STORE;
        if (x) return K_LOAD;
        return K_SIMPLE;
    endfunction

    task automatic model_step(input int k);
        int  mask;
        bit  retired;
        bit  finished;
        exp_t e;
        mask = (k == 0) ? 32'hFFFF : 32'hF;
        retired = 1'b0;
        finished = 1'b0;
        if (!rst_n) begin
            m_st[k] = (k == 1) ? M_FETCH : M_IDLE;
            m_fault[k] = 1'b0;
            m_ic[k] = 0;
            m_cc[k] = 0;
        end else begin
            if (m_st[k] == M_FETCH || m_st[k] == M_E1 || m_st[k] == M_E2)
                m_cc[k] = (m_cc[k] + 1) & mask;
            case (m_st[k])
                M_IDLE, M_HALT: if (start) begin
                    m_st[k] = M_FETCH;
                    m_ic[k] = 0;
                    m_cc[k] = 0;
                    m_fault[k] = 1'b0;
                end
                M_FETCH: if (mem_ready) m_st[k] = M_E1;
                M_E1: case (instr_kind(op, extra))
                    K_BAD:    begin m_st[k] = M_HALT; m_fault[k] = 1'b1; end
                    K_STOP:   begin m_st[k] = M_HALT; retired = 1'b1; end
                    K_STORE:  if (mem_ready) begin retired = 1'b1; finished = 1'b1; end
                    K_LOAD:   if (mem_ready) m_st[k] = M_E2;
                    default:  begin retired = 1'b1; finished = 1'b1; end
                endcase
                M_E2: begin retired = 1'b1; finished = 1'b1; end
                M_PAUSE: if (step || !step_mode) m_st[k] = M_FETCH;
                default: ;
            endcase
            if (retired) m_ic[k] = (m_ic[k] + 1) & mask;
            if (finished) m_st[k] = step_mode ? M_PAUSE : M_FETCH;
        end
        e.k = k;
        e.st = m_st[k];
        e.fault = m_fault[k];
        e.ic = m_ic[k];
        e.cc = m_cc[k];
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs on the falling edge and queue expectations.
    task automatic applyStimulus(input bit r, input bit s, input bit sm, input bit stp,
                                 input bit mr, input logic [3:0] o, input bit x);
        @(negedge clk);
        rst_n = r;
        start = s;
        step_mode = sm;
        step = stp;
        mem_ready = mr;
        op = o;
        extra = x;
        model_step(0);
        model_step(1);
    endtask

    task automatic run_op(input logic [3:0] o, input bit x, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 1, o, x);
    endtask

    // Directed check against a value fixed by the required behaviour.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every rising edge, compare each instance to its queued expectation.
    always begin
        exp_t e;
        logic [6:0] act_flags;
        logic [6:0] exp_flags;
        int act_ic;
        int act_cc;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.k == 0) begin
                act_flags = {f_a, e1_a, e2_a, busy_a, paused_a, halted_a, fault_a};
                act_ic = int'(ic_a);
                act_cc = int'(cc_a);
            end else begin
                act_flags = {f_b, e1_b, e2_b, busy_b, paused_b, halted_b, fault_b};
                act_ic = int'(ic_b);
                act_cc = int'(cc_b);
            end
            exp_flags = {e.st == M_FETCH, e.st == M_E1, e.st == M_E2,
                         e.st == M_FETCH || e.st == M_E1 || e.st == M_E2,
                         e.st == M_PAUSE, e.st == M_HALT, e.fault};
            checks++;
            if (act_flags !== exp_flags || act_ic !== e.ic || act_cc !== e.cc) begin
                failures++;
                $display("[TB] FAIL scoreboard inst=%0d flags(F,E1,E2,busy,paused,halted,fault) actual=%b expected=%b instr actual=%0d expected=%0d cycles actual=%0d expected=%0d",
                         e.k, act_flags, exp_flags, act_ic, e.ic, act_cc, e.cc);
            end
        end
    end

    initial begin
        // Reset state.
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 0);
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 0);
        settle();
        checkOutput("reset_phases", int'({f_a, e1_a, e2_a, busy_a}), 0);
        checkOutput("reset_auto_fetch", int'(f_b), 1);
        checkOutput("reset_counters", int'(ic_a) + int'(cc_a), 0);

        // LDA, STA, ADD, STP with memory always ready.
        applyStimulus(1, 1, 0, 0, 1, 4'd0, 1);
        run_op(4'd0, 1, 3);
        run_op(4'd1, 0, 2);
        run_op(4'd2, 1, 3);
        run_op(4'd7, 0, 2);
        settle();
        checkOutput("prog_halted", int'(halted_a), 1);
        checkOutput("prog_instr_count", int'(ic_a), 4);
        checkOutput("prog_cycle_count", int'(cc_a), 10);
        checkOutput("prog_fault", int'(fault_a), 0);

        // LDA with 3 fetch stalls and 2 execute stalls.
        applyStimulus(1, 1, 0, 0, 0, 4'd0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 4'd0, 1);
        settle();
        checkOutput("fetch_held_on_stall", int'(f_a), 1);
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 1);
        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 4'd0, 1);
        settle();
        checkOutput("exec1_held_on_stall", int'(e1_a), 1);
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 1);
        settle();
        checkOutput("exec2_after_stall", int'(e2_a), 1);
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 1);
        settle();
        checkOutput("stall_cycle_count", int'(cc_a), 8);
        checkOutput("stall_instr_count", int'(ic_a), 1);

        // Illegal opcode faults into HALT without retiring.
        run_op(4'd13, 0, 2);
        settle();
        checkOutput("illegal_fault", int'(fault_a), 1);
        checkOutput("illegal_halted", int'(halted_a), 1);
        checkOutput("illegal_not_retired", int'(ic_a), 1);
        applyStimulus(1, 1, 0, 0, 1, 4'd4, 0);
        settle();
        checkOutput("restart_fault_clear", int'(fault_a), 0);
        checkOutput("restart_counters_clear", int'(ic_a) + int'(cc_a), 0);

        // Single-step: JMP then LDI.
        applyStimulus(1, 0, 1, 0, 1, 4'd4, 0);
        applyStimulus(1, 0, 1, 0, 1, 4'd4, 0);
        settle();
        checkOutput("step_paused_after_jmp", int'(paused_a), 1);
        applyStimulus(1, 1, 1, 0, 0, 4'd8, 0);
        settle();
        checkOutput("start_ignored_in_pause", int'(paused_a), 1);
        applyStimulus(1, 0, 1, 1, 0, 4'd8, 0);
        applyStimulus(1, 0, 1, 1, 0, 4'd8, 0);
        settle();
        checkOutput("step_in_fetch_no_effect", int'(f_a), 1);
        applyStimulus(1, 0, 1, 0, 1, 4'd8, 0);
        applyStimulus(1, 0, 1, 0, 1, 4'd8, 0);
        applyStimulus(1, 0, 1, 0, 0, 4'd8, 0);
        settle();
        checkOutput("step_paused_after_ldi", int'(paused_a), 1);
        applyStimulus(1, 0, 0, 0, 0, 4'd8, 0);
        settle();
        checkOutput("drop_step_mode_fetch", int'(f_a), 1);

        // Reset in the middle of EXEC2.
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 1);
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 1);
        settle();
        checkOutput("reached_exec2", int'(e2_a), 1);
        applyStimulus(0, 0, 0, 0, 1, 4'd0, 1);
        settle();
        checkOutput("midreset_phases", int'({f_a, e1_a, e2_a, busy_a, halted_a}), 0);
        checkOutput("midreset_counters", int'(ic_a) + int'(cc_a), 0);
        applyStimulus(1, 1, 0, 0, 1, 4'd9, 0);
        settle();
        checkOutput("fetch_after_start", int'(f_a), 1);

        // 4-bit instance: 16 single-cycle retires wrap the instruction counter.
        applyStimulus(0, 0, 0, 0, 1, 4'd9, 0);
        applyStimulus(1, 1, 0, 0, 1, 4'd9, 0);
        run_op(4'd9, 0, 29);
        settle();
        checkOutput("wrap_before", int'(ic_b), 15);
        run_op(4'd9, 0, 2);
        settle();
        checkOutput("wrap_after", int'(ic_b), 0);

        // Randomized traffic checked entirely by the scoreboard.
        begin
            bit sm_level = 1'b0;
            for (int n = 0; n < 3000; n++) begin
                logic [3:0] o;
                bit x;
                if ($urandom_range(0, 63) == 0) sm_level = ~sm_level;
                o = 4'($urandom_range(0, 15));
                x = (o == 4'd0 || o == 4'd2 || o == 4'd3);
                if ($urandom_range(0, 9) == 0) x = ~x;
                applyStimulus($urandom_range(0, 199) != 0,
                              $urandom_range(0, 15) == 0,
                              sm_level,
                              $urandom_range(0, 7) == 0,
                              $urandom_range(0, 1) == 1,
                              o, x);
            end
        end

        settle();
        @(posedge clk);
        #3;
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
